// File: rtl/rr_arbiter4_v_pkg.sv
// Shared constants, state encoding and output bundle for the 4-way round-robin arbiter.
package rr_arbiter4_v_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Registered output bundle; everything the arbiter drives except o_any_req.
  typedef struct packed {
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] id;
    logic             busy;
    logic             timeout;
  } gnt_s;

endpackage

// File: rtl/rr_arbiter4_v_pick4.sv
// Rotating-priority picker: first set request at or after ptr, wrapping mod N_REQ.
// Also holds the OR4 reduction cell that produces the any-request flag.
module or4_v (
  input  logic [3:0] a,
  output logic       y
);
  assign y = |a;
endmodule

module rr_pick4_v
  import rr_arbiter4_v_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IDX_W-1:0] pick_id,
  output logic             valid
);

  logic             found;
  logic [IDX_W-1:0] idx;

  or4_v u_or4 (.a(req), .y(valid));

  // Walk ptr, ptr+1, ... with natural 2-bit wrap; first hit wins.
  always_comb begin
    pick    = '0;
    pick_id = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr + IDX_W'(i);
      if (!found && req[idx]) begin
        found      = 1'b1;
        pick[idx]  = 1'b1;
        pick_id    = idx;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4_v.sv
// Four-client round-robin arbiter with registered one-hot grant held until release,
// owner request drop, or the hold limit forces a handover through one idle cycle.
module rr_arbiter4_v
  import rr_arbiter4_v_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_release,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0] o_gnt_id,
  output logic             o_busy,
  output logic             o_any_req,
  output logic             o_timeout
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  localparam logic             HOLD_EN  = (MAX_HOLD != 0);

  if ((2 ** CNT_W) <= MAX_HOLD) begin : g_bad_cnt_w
    $error("CNT_W too narrow for MAX_HOLD");
  end

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  gnt_s             out_q, out_d;

  logic [N_REQ-1:0] pick;
  logic [IDX_W-1:0] pick_id;
  logic             pick_vld;
  logic             rel, lim;

  rr_pick4_v u_pick (
    .req     (i_req),
    .ptr     (ptr_q),
    .pick    (pick),
    .pick_id (pick_id),
    .valid   (pick_vld)
  );

  assign o_any_req = pick_vld;
  assign o_gnt     = out_q.gnt;
  assign o_gnt_id  = out_q.id;
  assign o_busy    = out_q.busy;
  assign o_timeout = out_q.timeout;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    out_d         = out_q;
    out_d.timeout = 1'b0;
    // Release outranks the hold limit, so a coincident limit never pulses timeout.
    rel           = i_release | ~i_req[out_q.id];
    lim           = HOLD_EN && (cnt_q == HOLD_LIM);
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d    = ST_GRANT;
          out_d.gnt  = pick;
          out_d.id   = pick_id;
          out_d.busy = 1'b1;
          cnt_d      = CNT_W'(1);
        end
      end
      ST_GRANT: begin
        if (rel || lim) begin
          state_d       = ST_IDLE;
          out_d.gnt     = '0;
          out_d.busy    = 1'b0;
          out_d.timeout = ~rel;
          ptr_d         = out_q.id + IDX_W'(1);
        end else if (cnt_q != '1) begin
          // Limit case exits above, so only the unlimited mode needs saturation here.
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rr_arbiter4_v.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized
// traffic compared every cycle against an event-level round-robin model.
module tb_rr_arbiter4_v;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0;
  logic       rel = 1'b0;
  logic [3:0] o_gnt;
  logic [1:0] o_gnt_id;
  logic       o_busy, o_any_req, o_timeout;

  int total = 0;
  int bad = 0;

  rr_arbiter4_v #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_req     (req),
    .i_release (rel),
    .o_gnt     (o_gnt),
    .o_gnt_id  (o_gnt_id),
    .o_busy    (o_busy),
    .o_any_req (o_any_req),
    .o_timeout (o_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner = -1 when nobody holds the resource.
  int m_owner = -1;
  int m_ptr = 0;
  int m_held = 0;
  int m_id = 0;
  bit m_to = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    bit         r_rel, r_lim;
    logic [3:0] one, m_gnt;
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_held = 0; m_id = 0; m_to = 1'b0;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      for (int k = 0; k < 4; k++)
        if (m_owner < 0 && req[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
      if (m_owner >= 0) begin
        m_held = 1;
        m_id = m_owner;
      end
    end else begin
      r_rel = rel || !req[m_owner];
      r_lim = (MAX_HOLD != 0) && (m_held == MAX_HOLD);
      if (r_rel || r_lim) begin
        m_to = !r_rel;
        m_ptr = (m_owner + 1) % 4;
        m_owner = -1;
      end else begin
        m_to = 1'b0;
        m_held++;
      end
    end
    #1;
    one = 4'b0001;
    m_gnt = (m_owner >= 0) ? (one << m_owner) : 4'b0000;
    chk("m_gnt", o_gnt, m_gnt);
    chk("m_busy", o_busy, (m_owner >= 0));
    chk("m_timeout", o_timeout, m_to);
    chk("m_any_req", o_any_req, |req);
    if (m_owner >= 0 || !rst_n) chk("m_gnt_id", o_gnt_id, m_id);
  end

  initial begin
    int exp_order[5];
    int n;
    exp_order = '{3, 0, 1, 2, 3};

    repeat (2) @(negedge clk);
    chk("rst_gnt", o_gnt, 0);
    chk("rst_id", o_gnt_id, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_timeout", o_timeout, 0);
    rst_n = 1'b1;

    // Single requester 2, then release pulse.
    @(negedge clk); req = 4'b0100;
    @(negedge clk);
    chk("d1_gnt", o_gnt, 4'b0100);
    chk("d1_id", o_gnt_id, 2);
    chk("d1_busy", o_busy, 1);
    rel = 1'b1;
    @(negedge clk); rel = 1'b0;
    chk("d1_rel_gnt", o_gnt, 0);
    chk("d1_rel_busy", o_busy, 0);
    req = 4'b1111;
    @(negedge clk);

    // All requesting: each owner releases after 2 grant cycles; ptr started at 3.
    for (int g = 0; g < 5; g++) begin
      chk("d2_order", o_gnt_id, exp_order[g]);
      chk("d2_gnt", o_gnt, 1 << exp_order[g]);
      @(negedge clk);
      chk("d2_hold", o_gnt, 1 << exp_order[g]);
      rel = 1'b1;
      @(negedge clk); rel = 1'b0;
      chk("d2_gap", o_gnt, 0);
      @(negedge clk);
    end
    req = 4'b0000;
    repeat (2) @(negedge clk);

    // Hold limit with client 0 alone.
    req = 4'b0001;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_gnt == 4'b0001) n++;
      else break;
    end
    chk("d3_hold_len", n, MAX_HOLD);
    chk("d3_timeout", o_timeout, 1);
    chk("d3_gap", o_gnt, 0);
    @(negedge clk);
    chk("d3_regrant", o_gnt, 4'b0001);
    chk("d3_timeout_clr", o_timeout, 0);

    // Owner drops its request; ptr is 1 after the timeout, so client 1 goes next.
    req = 4'b0010;
    @(negedge clk); chk("d4_drop0", o_gnt, 0);
    @(negedge clk); chk("d4_gnt1", o_gnt, 4'b0010);
    req = 4'b1000;
    @(negedge clk); chk("d4_drop1", o_gnt, 0);
    @(negedge clk);
    chk("d4_wrap_gnt", o_gnt, 4'b1000);
    chk("d4_wrap_id", o_gnt_id, 3);
    req = 4'b0000;
    @(negedge clk);
    req = 4'b0010;
    @(negedge clk); chk("d5_pre", o_gnt, 4'b0010);

    // Asynchronous reset mid-grant.
    #2 rst_n = 1'b0;
    #1;
    chk("d5_async_gnt", o_gnt, 0);
    chk("d5_async_busy", o_busy, 0);
    req = 4'b1010;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("d5_post_gnt", o_gnt, 4'b0010);
    chk("d5_post_id", o_gnt_id, 1);

    // Release coincident with the hold limit: no timeout pulse.
    req = 4'b0001;
    @(negedge clk); chk("d6_gap", o_gnt, 0);
    @(negedge clk); chk("d6_gnt", o_gnt, 4'b0001);
    repeat (MAX_HOLD - 1) @(negedge clk);
    chk("d6_still", o_gnt, 4'b0001);
    rel = 1'b1;
    @(negedge clk); rel = 1'b0;
    chk("d6_rel_gnt", o_gnt, 0);
    chk("d6_no_timeout", o_timeout, 0);

    // Randomized traffic; the model process checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
      rel = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
      end
    end
    rel = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
